// File: rtl/sort7_stream_if.sv
// -----------------------------------------------------------------------------
// sort7_stream_if
// Stream bundle for the 7-entry sorter: one ready/valid input stream and one
// ready/valid output stream with an end-of-batch marker.
//
// Handshake rule (both streams): a beat transfers on a rising clock edge where
// valid and ready are both high. The sender holds data stable while valid is
// high and ready is low; ready may be high without valid and never depends
// combinationally on valid.
//
// Signals
//   in_valid  : producer -> sorter, in_data is valid
//   in_ready  : sorter -> producer, sorter accepts a value this cycle
//   in_data   : producer -> sorter, unsigned W-bit value
//   out_valid : sorter -> consumer, out_data holds the next sorted value
//   out_ready : consumer -> sorter, consumer takes out_data this cycle
//   out_data  : sorter -> consumer, largest remaining value
//   out_last  : sorter -> consumer, marks the smallest (final) value of a batch
//
// Modports
//   slave  : the sorter side
//   master : the producer/consumer (environment) side
// -----------------------------------------------------------------------------
interface sort7_stream_if #(
  parameter int W = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort7_stream.sv
// -----------------------------------------------------------------------------
// sort7_stream
// Sequential N-entry (N = 7) insertion sorter. Values arrive one per cycle over
// the input stream and are kept in descending order in a register array. Once
// the Nth value is accepted the block drains the array largest-first over the
// output stream, then returns to loading. Load and drain never overlap.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous, active-high reset
//   s        : stream bundle (slave side), see sort7_stream_if
//   busy     : high when entries are held or a drain is in progress
//   o_dbg_st : current FSM state (0 = LOAD, 1 = DRAIN)
//
// All outputs are decoded from registered state; there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module sort7_stream #(
  parameter int W = 8,
  parameter int N = 7
) (
  input  logic            clk,
  input  logic            rst,
  sort7_stream_if.slave   s,
  output logic            busy,
  output logic            o_dbg_st
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          r_st;
  state_t          w_st_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [W-1:0]    r_arr     [N];
  logic [W-1:0]    w_arr_nxt [N];

  // Insertion network: w_ge marks occupied entries that stay ahead of the new
  // value (>= keeps ties stable). Because the array is descending, w_ge is a
  // prefix of ones; the new value lands at the first zero and everything after
  // it moves down one slot.
  logic [N-1:0]    w_ge;
  logic [W-1:0]    w_ins     [N];

  always_comb begin
    w_ge = '0;
    for (int i = 0; i < N; i++) begin
      w_ge[i] = (CW'(i) < r_count) && (r_arr[i] >= s.in_data);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_ins[i] = r_arr[i];
    end
    w_ins[0] = w_ge[0] ? r_arr[0] : s.in_data;
    for (int i = 1; i < N; i++) begin
      if (w_ge[i]) begin
        w_ins[i] = r_arr[i];
      end else if (w_ge[i-1]) begin
        w_ins[i] = s.in_data;
      end else begin
        w_ins[i] = r_arr[i-1];
      end
    end
  end

  // Next-state logic. in_ready is exactly (r_st == ST_LOAD) and out_valid is
  // exactly (r_st == ST_DRAIN), so the handshakes reduce to the other side's
  // valid/ready within each state.
  always_comb begin
    w_st_nxt    = r_st;
    w_count_nxt = r_count;
    for (int i = 0; i < N; i++) begin
      w_arr_nxt[i] = r_arr[i];
    end

    case (r_st)
      ST_LOAD: begin
        if (s.in_valid) begin
          for (int i = 0; i < N; i++) begin
            w_arr_nxt[i] = w_ins[i];
          end
          w_count_nxt = r_count + CW'(1);
          if (r_count == CW'(N - 1)) begin
            w_st_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (s.out_ready) begin
          // Shift toward arr[0]; the vacated tail reads as zero so a later
          // load never sees stale data beyond count.
          for (int i = 0; i < N - 1; i++) begin
            w_arr_nxt[i] = r_arr[i+1];
          end
          w_arr_nxt[N-1] = '0;
          w_count_nxt    = r_count - CW'(1);
          if (r_count == CW'(1)) begin
            w_st_nxt    = ST_LOAD;
            w_count_nxt = '0;
          end
        end
      end
      default: begin
        w_st_nxt    = ST_LOAD;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= ST_LOAD;
      r_count <= '0;
      for (int i = 0; i < N; i++) begin
        r_arr[i] <= '0;
      end
    end else begin
      r_st    <= w_st_nxt;
      r_count <= w_count_nxt;
      for (int i = 0; i < N; i++) begin
        r_arr[i] <= w_arr_nxt[i];
      end
    end
  end

  assign s.in_ready  = (r_st == ST_LOAD);
  assign s.out_valid = (r_st == ST_DRAIN);
  assign s.out_last  = (r_st == ST_DRAIN) && (r_count == CW'(1));
  assign s.out_data  = r_arr[0];
  assign busy        = (r_count != '0) || (r_st == ST_DRAIN);
  assign o_dbg_st    = r_st;

endmodule

// File: tb/tb_sort7_stream.sv
// -----------------------------------------------------------------------------
// tb_sort7_stream
// Self-checking bench for sort7_stream. Inputs are driven on the falling edge;
// the output monitor samples 3 time units after the falling edge, i.e. just
// before the next rising edge, so it sees exactly the values of each handshake.
// -----------------------------------------------------------------------------
module tb_sort7_stream;

  localparam int W = 8;

  logic clk;
  logic rst;
  logic busy;
  logic dbg_st;

  sort7_stream_if #(.W(W)) sif ();

  sort7_stream #(.W(W), .N(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (sif.slave),
    .busy     (busy),
    .o_dbg_st (dbg_st)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] bat [7];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           beat    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: descending sort of the batch, pushed as expected beats.
  task automatic push_sorted();
    logic [W-1:0] t [7];
    logic [W-1:0] tmp;
    for (int i = 0; i < 7; i++) t[i] = bat[i];
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 6 - i; j++) begin
        if (t[j] < t[j+1]) begin
          tmp    = t[j];
          t[j]   = t[j+1];
          t[j+1] = tmp;
        end
      end
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(t[i]);
  endtask

  task automatic set_bat(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6);
    bat[0] = a0; bat[1] = a1; bat[2] = a2; bat[3] = a3;
    bat[4] = a4; bat[5] = a5; bat[6] = a6;
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    #3;
    if (!rst && sif.out_valid && sif.out_ready) begin
      check("out_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("out_data", 32'(sif.out_data), 32'(exp_q.pop_front()));
        check("out_last", 32'(sif.out_last), 32'(beat == 6));
        beat = (beat == 6) ? 0 : beat + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_in_ready",  32'(sif.in_ready), 1);
    check("rst_out_valid", 32'(sif.out_valid), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_out_last",  32'(sif.out_last), 0);
    check("rst_out_data",  32'(sif.out_data), 0);
    exp_q.delete();
    beat = 0;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle between values, 2 random idles
  task automatic load(input int n, input int gap_mode);
    for (int i = 0; i < n; i++) begin
      int idle;
      idle = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      for (int k = 0; k < idle; k++) begin
        @(negedge clk);
        sif.in_valid = 1'b0;
        sif.in_data  = W'($urandom_range(0, 255));
      end
      @(negedge clk);
      sif.in_valid = 1'b1;
      sif.in_data  = bat[i];
      #1;
      check("load_in_ready",  32'(sif.in_ready), 1);
      check("load_out_valid", 32'(sif.out_valid), 0);
      @(posedge clk);
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
    if (n == 7) begin
      push_sorted();
      #1;
      check("latency_out_valid", 32'(sif.out_valid), 1);
      check("drain_in_ready",    32'(sif.in_ready), 0);
      check("drain_busy",        32'(busy), 1);
    end
  endtask

  // mode: 0 out_ready held, 1 random, 2 stall 3 cycles then alternate
  task automatic drain(input int mode);
    int cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      if (cyc >= 200) begin
        check("drain_timeout", 32'(exp_q.size()), 0);
        exp_q.delete();
        beat = 0;
        break;
      end
      case (mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = 1'($urandom_range(0, 1));
        default: sif.out_ready = (cyc >= 3) ? 1'(cyc % 2) : 1'b0;
      endcase
      #1;
      check("drain_in_ready_low", 32'(sif.in_ready), 0);
      if (mode == 2 && cyc < 3) begin
        check("stall_data", 32'(sif.out_data), 32'(exp_q[0]));
        check("stall_last", 32'(sif.out_last), 32'(beat == 6));
      end
      cyc++;
    end
    sif.out_ready = 1'b0;
    #1;
    check("post_in_ready",  32'(sif.in_ready), 1);
    check("post_out_valid", 32'(sif.out_valid), 0);
    check("post_busy",      32'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    #1;
    do_reset();

    // basic sort
    set_bat(36, 129, 9, 99, 13, 141, 101);
    load(7, 0);
    drain(0);

    // duplicates and extremes
    set_bat(0, 255, 7, 255, 0, 7, 128);
    load(7, 0);
    drain(0);

    // ascending then descending, back to back
    set_bat(1, 2, 3, 4, 5, 6, 7);
    load(7, 0);
    drain(0);
    set_bat(7, 6, 5, 4, 3, 2, 1);
    load(7, 0);
    drain(0);

    // input gaps and output backpressure
    set_bat(50, 40, 60, 10, 30, 70, 20);
    load(7, 1);
    drain(2);

    // reset during load
    set_bat(11, 22, 33, 44, 55, 66, 77);
    load(4, 0);
    @(negedge clk);
    do_reset();

    // reset during drain after two outputs
    set_bat(90, 80, 70, 60, 50, 40, 30);
    load(7, 0);
    @(negedge clk);
    sif.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sif.out_ready = 1'b0;
    check("mid_drain_remaining", 32'(exp_q.size()), 5);
    do_reset();

    // clean batch after the resets
    set_bat(3, 1, 2, 7, 5, 4, 6);
    load(7, 0);
    drain(0);

    // random regression
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < 7; i++) bat[i] = W'($urandom_range(0, 255));
      if (b == 5) bat[3] = bat[1];
      load(7, 2);
      drain(1);
    end

    check("q_empty_end", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
